// File: rtl/ins_prefetch_buf.sv
// Instruction prefetch buffer: streams sequential words from memory into a FIFO
// and serves core fetches from its head, flushing on any redirect.
module ins_prefetch_buf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exIns_ren,
    input  logic [31:0] exIns_addr,
    output logic        exIns_valid,
    output logic [31:0] exIns_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]    state;
    logic [31:0]   head_addr;
    logic [31:0]   fetch_addr;
    logic [CW-1:0] count;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_mem [DEPTH];

    logic [31:0]   req_addr;
    logic [CW:0]   occ;
    logic [CW-1:0] drop_nxt;
    logic          active;
    logic          addr_match;
    logic          hit;
    logic          redirect;
    logic          grant;
    logic          push;
    logic          pop;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^exIns_addr[1:0];
    assign req_addr   = {exIns_addr[31:2], 2'b00};
    assign active     = (state != IDLE);
    assign addr_match = (exIns_addr[31:2] == head_addr[31:2]);

    assign hit      = exIns_ren & active & (count != '0) & addr_match;
    assign redirect = exIns_ren & active & !hit & !addr_match;

    // Granted-but-unanswered requests reserve a FIFO slot, so a push never overflows.
    assign occ      = {1'b0, count} + {1'b0, outst};
    assign mem_req  = (state == STREAM) & !redirect & (occ < DEPTH_W);
    assign mem_addr = fetch_addr;
    assign grant    = mem_req & mem_gnt;

    assign push     = (state == STREAM) & mem_rvalid & !redirect;
    assign pop      = hit;
    assign drop_nxt = outst - CW'(mem_rvalid);

    assign exIns_valid = hit;
    assign exIns_in    = (count != '0) ? fifo_mem[rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            head_addr  <= '0;
            fetch_addr <= '0;
            count      <= '0;
            outst      <= '0;
            drop_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (exIns_ren) begin
                        head_addr  <= req_addr;
                        fetch_addr <= req_addr;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (redirect) begin
                        head_addr  <= req_addr;
                        fetch_addr <= req_addr;
                        count      <= '0;
                        rd_ptr     <= '0;
                        wr_ptr     <= '0;
                        outst      <= '0;
                        drop_cnt   <= drop_nxt;
                        state      <= (drop_nxt != '0) ? DRAIN : STREAM;
                    end else begin
                        if (grant) begin
                            fetch_addr <= fetch_addr + 32'd4;
                        end
                        if (push) begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                        if (pop) begin
                            rd_ptr    <= rd_ptr + 1'b1;
                            head_addr <= head_addr + 32'd4;
                        end
                        count <= count + CW'(push) - CW'(pop);
                        outst <= outst + CW'(grant) - CW'(mem_rvalid);
                    end
                end
                DRAIN: begin
                    // Stale responses from before the redirect are swallowed here.
                    if (redirect) begin
                        head_addr  <= req_addr;
                        fetch_addr <= req_addr;
                    end
                    if (mem_rvalid) begin
                        drop_cnt <= drop_cnt - 1'b1;
                        if (drop_cnt == CW'(1)) begin
                            state <= STREAM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_prefetch_buf.sv
// Directed bench for ins_prefetch_buf with a fixed-latency in-order memory model.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_ins_prefetch_buf;

    logic        clk;
    logic        rst;
    logic        exIns_ren;
    logic [31:0] exIns_addr;
    logic        exIns_valid;
    logic [31:0] exIns_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int pass_cnt;
    int tot_cnt;
    int ovf_cnt;

    logic [31:0] q_addr [$];
    int          q_age  [$];
    bit          hold;
    bit          stray;
    bit          deliv;

    ins_prefetch_buf #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .exIns_ren  (exIns_ren),
        .exIns_addr (exIns_addr),
        .exIns_valid(exIns_valid),
        .exIns_in   (exIns_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory answers a grant two edges later unless held.
    task automatic prep();
        deliv      = 1'b0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
        end else if (!hold && q_addr.size() > 0 && q_age[0] >= 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mword(q_addr[0]);
            deliv      = 1'b1;
        end
        #1;
    endtask

    task automatic tick();
        bit          g;
        logic [31:0] ga;
        g  = mem_req & mem_gnt;
        ga = mem_addr;
        if (dut.push && !dut.pop && int'(dut.count) == 4) ovf_cnt++;
        @(posedge clk);
        #1;
        if (rst) begin
            q_addr.delete();
            q_age.delete();
        end else begin
            if (deliv) begin
                void'(q_addr.pop_front());
                void'(q_age.pop_front());
            end
            foreach (q_age[i]) q_age[i]++;
            if (g) begin
                q_addr.push_back(ga);
                q_age.push_back(0);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        exIns_ren  = 1'b0;
        exIns_addr = 32'd0;
        hold       = 1'b0;
        stray      = 1'b0;
        prep();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        prep();
        tot_cnt++; if (exIns_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", exIns_valid); else pass_cnt++;
        tot_cnt++; if (exIns_in !== 32'd0) $display("FAIL rst_in: got %h want 0", exIns_in); else pass_cnt++;
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req); else pass_cnt++;
        tot_cnt++; if (mem_addr !== 32'd0) $display("FAIL rst_maddr: got %h want 0", mem_addr); else pass_cnt++;
        tick();
    endtask

    task automatic test_fill_and_backpressure();
        logic [31:0] exp_a [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset();
        exIns_ren  = 1'b1;
        exIns_addr = 32'h0;
        prep();
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL fill_idle_req: got %b want 0", mem_req); else pass_cnt++;
        tick();
        exIns_ren = 1'b0;
        for (int c = 0; c < 4; c++) begin
            prep();
            tot_cnt++;
            if (mem_req !== 1'b1 || mem_addr !== exp_a[c])
                $display("FAIL fill_addr%0d: got req=%b addr=%h want req=1 addr=%h", c, mem_req, mem_addr, exp_a[c]);
            else pass_cnt++;
            tick();
        end
        prep();
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL fill_4inflight_req: got %b want 0", mem_req); else pass_cnt++;
        tick();
        prep();
        tick();
        prep();
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL full_noren_req: got %b want 0", mem_req); else pass_cnt++;
        tot_cnt++; if (exIns_valid !== 1'b0) $display("FAIL full_noren_valid: got %b want 0", exIns_valid); else pass_cnt++;
        exIns_ren  = 1'b1;
        exIns_addr = 32'h0;
        #1;
        tot_cnt++; if (exIns_valid !== 1'b1) $display("FAIL full_hit_valid: got %b want 1", exIns_valid); else pass_cnt++;
        tot_cnt++; if (exIns_in !== mword(32'h0)) $display("FAIL full_hit_in: got %h want %h", exIns_in, mword(32'h0)); else pass_cnt++;
        tick();
        exIns_ren = 1'b0;
        prep();
        tot_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10)
            $display("FAIL refill_req: got req=%b addr=%h want req=1 addr=00000010", mem_req, mem_addr);
        else pass_cnt++;
        tot_cnt++; if (exIns_in !== mword(32'h4)) $display("FAIL refill_head: got %h want %h", exIns_in, mword(32'h4)); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        do_reset();
        a = 32'h0;
        for (int c = 0; c < 16; c++) begin
            exIns_ren  = 1'b1;
            exIns_addr = a;
            prep();
            if (c < 4) begin
                tot_cnt++; if (exIns_valid !== 1'b0) $display("FAIL b2b_early%0d: got valid=%b want 0", c, exIns_valid); else pass_cnt++;
            end else begin
                tot_cnt++;
                if (exIns_valid !== 1'b1 || exIns_in !== mword(a))
                    $display("FAIL b2b_word%0d: got valid=%b in=%h want valid=1 in=%h", c, exIns_valid, exIns_in, mword(a));
                else pass_cnt++;
                a = a + 32'd4;
            end
            tick();
        end
        exIns_ren = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        exIns_ren  = 1'b1;
        exIns_addr = 32'h10;
        prep();
        tick();
        exIns_ren = 1'b0;
        for (int c = 0; c < 5; c++) begin
            prep();
            tick();
        end
        hold       = 1'b1;
        exIns_ren  = 1'b1;
        exIns_addr = 32'h100;
        prep();
        tot_cnt++; if (exIns_valid !== 1'b0) $display("FAIL redir_valid: got %b want 0", exIns_valid); else pass_cnt++;
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL redir_req: got %b want 0", mem_req); else pass_cnt++;
        tick();
        prep();
        tot_cnt++; if (exIns_in !== 32'd0) $display("FAIL drain_in: got %h want 0", exIns_in); else pass_cnt++;
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL drain_req: got %b want 0", mem_req); else pass_cnt++;
        tick();
        hold = 1'b0;
        prep();
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL drain_last_req: got %b want 0", mem_req); else pass_cnt++;
        tick();
        prep();
        tot_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100)
            $display("FAIL redir_restart: got req=%b addr=%h want req=1 addr=00000100", mem_req, mem_addr);
        else pass_cnt++;
        tick();
        prep();
        tick();
        prep();
        tick();
        prep();
        tot_cnt++;
        if (exIns_valid !== 1'b1 || exIns_in !== mword(32'h100))
            $display("FAIL redir_first_word: got valid=%b in=%h want valid=1 in=%h", exIns_valid, exIns_in, mword(32'h100));
        else pass_cnt++;
        tick();
        exIns_ren = 1'b0;
    endtask

    task automatic test_push_pop();
        logic [31:0] exp_a [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
        do_reset();
        exIns_ren  = 1'b1;
        exIns_addr = 32'h200;
        prep();
        tick();
        exIns_ren = 1'b0;
        for (int c = 0; c < 4; c++) begin
            prep();
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            exIns_ren  = 1'b1;
            exIns_addr = exp_a[c];
            prep();
            tot_cnt++;
            if (exIns_valid !== 1'b1 || exIns_in !== mword(exp_a[c]))
                $display("FAIL pp_word%0d: got valid=%b in=%h want valid=1 in=%h", c, exIns_valid, exIns_in, mword(exp_a[c]));
            else pass_cnt++;
            if (c == 0) begin
                tot_cnt++; if (mem_req !== 1'b0) $display("FAIL pp_req_full: got %b want 0", mem_req); else pass_cnt++;
            end
            if (c == 1) begin
                tot_cnt++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h210)
                    $display("FAIL pp_req_next: got req=%b addr=%h want req=1 addr=00000210", mem_req, mem_addr);
                else pass_cnt++;
            end
            tick();
        end
        exIns_ren = 1'b0;
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        exIns_ren  = 1'b1;
        exIns_addr = 32'h300;
        prep();
        tick();
        exIns_ren = 1'b0;
        prep();
        tick();
        prep();
        tick();
        hold       = 1'b1;
        exIns_ren  = 1'b1;
        exIns_addr = 32'h500;
        prep();
        tick();
        exIns_ren = 1'b0;
        prep();
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL rd_drain_req: got %b want 0", mem_req); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        hold  = 1'b0;
        stray = 1'b1;
        prep();
        tot_cnt++; if (exIns_valid !== 1'b0) $display("FAIL rd_valid: got %b want 0", exIns_valid); else pass_cnt++;
        tot_cnt++; if (exIns_in !== 32'd0) $display("FAIL rd_in: got %h want 0", exIns_in); else pass_cnt++;
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL rd_req: got %b want 0", mem_req); else pass_cnt++;
        tot_cnt++; if (mem_addr !== 32'd0) $display("FAIL rd_maddr: got %h want 0", mem_addr); else pass_cnt++;
        tick();
        stray      = 1'b0;
        exIns_ren  = 1'b1;
        exIns_addr = 32'h40;
        prep();
        tot_cnt++; if (mem_req !== 1'b0) $display("FAIL rd_idle_req: got %b want 0", mem_req); else pass_cnt++;
        tick();
        exIns_ren = 1'b0;
        prep();
        tot_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40)
            $display("FAIL rd_restart: got req=%b addr=%h want req=1 addr=00000040", mem_req, mem_addr);
        else pass_cnt++;
        tick();
        prep();
        tick();
        prep();
        tick();
        exIns_ren  = 1'b1;
        exIns_addr = 32'h40;
        prep();
        tot_cnt++;
        if (exIns_valid !== 1'b1 || exIns_in !== mword(32'h40))
            $display("FAIL rd_first_word: got valid=%b in=%h want valid=1 in=%h", exIns_valid, exIns_in, mword(32'h40));
        else pass_cnt++;
        tick();
        exIns_ren = 1'b0;
    endtask

    initial begin
        pass_cnt   = 0;
        tot_cnt    = 0;
        ovf_cnt    = 0;
        rst        = 1'b1;
        exIns_ren  = 1'b0;
        exIns_addr = 32'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        hold       = 1'b0;
        stray      = 1'b0;
        deliv      = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill_and_backpressure();
        test_back_to_back();
        test_redirect();
        test_push_pop();
        test_reset_in_drain();
        tot_cnt++; if (ovf_cnt !== 0) $display("FAIL fifo_overflow: got %0d pushes into full FIFO want 0", ovf_cnt); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
